ddr_wdata_scheduler: RTL

Buffers 512-bit DDR write data arriving on an AXI4-Stream slave in a small FIFO. Releases it to the DDR write-data path only against accepted write commands. Each command carries a beat count; the block waits until that many beats are buffered, then streams them out back-to-back with valid/last qualifiers. It replaces the always-ready single-register capture with real backpressure and command-aligned sequencing.

---
 rtl/ddr_wdata_scheduler_if.sv | 34 +++
 rtl/ddr_wdata_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ddr_wdata_scheduler_if.sv
// Bundles the write-data stream, the command handshake and the DDR-side outputs
// of the write-data scheduler into one interface.
interface ddr_wdata_scheduler_if #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] S_AXIS_TDATA;
    logic              S_AXIS_TVALID;
    logic              S_AXIS_TREADY;
    logic              cmd_valid;
    logic [CNT_W-1:0]  cmd_beats;
    logic              cmd_ready;
    logic [DATA_W-1:0] ddr_wdata;
    logic              ddr_wvalid;
    logic              ddr_wlast;
    logic              cmd_done;
    logic [LVL_W-1:0]  fifo_level;
    logic              err_oversize;

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TVALID, cmd_valid, cmd_beats,
        output S_AXIS_TREADY, cmd_ready, ddr_wdata, ddr_wvalid, ddr_wlast,
               cmd_done, fifo_level, err_oversize
    );

    modport master (
        output S_AXIS_TDATA, S_AXIS_TVALID, cmd_valid, cmd_beats,
        input  S_AXIS_TREADY, cmd_ready, ddr_wdata, ddr_wvalid, ddr_wlast,
               cmd_done, fifo_level, err_oversize
    );
endinterface

// File: rtl/ddr_wdata_scheduler.sv
// Buffers DDR write beats in a circular FIFO and releases them as back-to-back
// bursts only once a command's full beat count is buffered.
module ddr_wdata_scheduler #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    ddr_wdata_scheduler_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  left_q, left_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic              wlast_q, wlast_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tready_c;
    logic              push_c;
    logic              pop_c;

    assign tready_c = (level_q < DEPTH_L);
    assign push_c   = bus.S_AXIS_TVALID && tready_c;
    assign pop_c    = (state_q == ST_ISSUE);

    // Next-state, FIFO bookkeeping and output staging
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        left_d   = left_q;
        wdata_d  = wdata_q;
        wvalid_d = 1'b0;
        wlast_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_beats == '0) begin
                        done_d = 1'b1;
                    end else if (32'(bus.cmd_beats) > DEPTH) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        left_d  = LVL_W'(bus.cmd_beats);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (level_q >= left_q) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                left_d = left_q - LVL_W'(1);
                if (left_q == LVL_W'(1)) begin
                    wlast_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wdata_d  = mem_q[rd_ptr_q];
            wvalid_d = 1'b1;
        end

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= bus.S_AXIS_TDATA;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            left_q   <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            left_q   <= left_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            wlast_q  <= wlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.S_AXIS_TREADY = tready_c;
    assign bus.cmd_ready     = rst_n && (state_q == ST_IDLE);
    assign bus.ddr_wdata     = wdata_q;
    assign bus.ddr_wvalid    = wvalid_q;
    assign bus.ddr_wlast     = wlast_q;
    assign bus.cmd_done      = done_q;
    assign bus.fifo_level    = level_q;
    assign bus.err_oversize  = err_q;

endmodule
